// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmitter arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  // Ceiling log2, never less than 1 so counters for tiny ranges still get a bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority select: first set request at or after ptr, wrapping.
import uart_tx_arb_pkg::*;

module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  localparam int PW = IW + 1;

  logic [PW-1:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + PW'(k);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found                = 1'b1;
        idx                  = pos[IW-1:0];
        onehot[pos[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of one UART transmitter: burst lock, TXRDY pacing, baud-tick gap between owners.
//
// state | meaning
// IDLE  | no owner; pick next requester from the rotating pointer
// LOAD  | owner holds grant; strobe its byte once TXRDY is high
// HOLD  | one cycle after a strobe while TXRDY falls; decide end of burst
// GAP   | grant dropped; wait GAP_TICKS baud ticks before next arbitration
import uart_tx_arb_pkg::*;

module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int GAP_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   last,
  input  logic [8*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   gnt,
  input  logic                 baud_en,
  input  logic                 txrdy,
  output logic                 tx_wen,
  output logic [7:0]           tx_data,
  output logic                 busy
);

  localparam int IW = clog2(NUM_REQ);
  localparam int BW = clog2(MAX_BURST + 1);
  localparam int GW = clog2(GAP_TICKS + 1);

  arb_state_t state_q, state_d;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner_idx;
  logic [IW-1:0]      next_ptr;
  logic [BW-1:0]      burst_cnt;
  logic [GW-1:0]      gap_cnt;
  logic               last_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_found;

  logic               req_g;
  logic               do_write;
  logic               burst_done;
  logic               gap_done;
  logic               enter_gap;
  logic [7:0]         data_sel;

  logic [NUM_REQ-1:0] gnt_d;
  logic [NUM_REQ-1:0] ack_d;
  logic               tx_wen_d;
  logic [7:0]         tx_data_d;
  logic               busy_d;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_comb begin
    data_sel = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_idx == IW'(k)) data_sel = data[8*k +: 8];
    end
  end

  assign req_g      = req[owner_idx];
  assign do_write   = (state_q == ST_LOAD) && req_g && txrdy;
  assign burst_done = last_q || (burst_cnt == BW'(MAX_BURST));
  // Gap timer is a down-counter loaded on GAP entry; the last tick ends the gap.
  assign gap_done   = (GAP_TICKS == 0) || (baud_en && (gap_cnt == GW'(1)));
  assign enter_gap  = (state_d == ST_GAP) && (state_q != ST_GAP);
  assign next_ptr   = (owner_idx == IW'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;

  // State register plus all registered outputs and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt       <= '0;
      ack       <= '0;
      tx_wen    <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      ptr       <= '0;
      owner_idx <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      ack     <= ack_d;
      tx_wen  <= tx_wen_d;
      tx_data <= tx_data_d;
      busy    <= busy_d;

      if (state_q == ST_IDLE && pick_found) begin
        owner_idx <= pick_idx;
        burst_cnt <= '0;
        last_q    <= 1'b0;
      end

      if (do_write) begin
        burst_cnt <= burst_cnt + 1'b1;
        last_q    <= last[owner_idx];
      end

      if (enter_gap) begin
        gap_cnt <= GW'(GAP_TICKS);
        ptr     <= next_ptr;
      end else if (state_q == ST_GAP && baud_en && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_found) state_d = ST_LOAD;
      ST_LOAD: begin
        if (!req_g)     state_d = ST_GAP;
        else if (txrdy) state_d = ST_HOLD;
      end
      ST_HOLD: state_d = burst_done ? ST_GAP : ST_LOAD;
      ST_GAP:  if (gap_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = gnt;
    ack_d     = '0;
    tx_wen_d  = 1'b0;
    tx_data_d = tx_data;
    busy_d    = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: if (pick_found) gnt_d = pick_onehot;
      ST_LOAD: begin
        if (!req_g) begin
          gnt_d = '0;
        end else if (txrdy) begin
          ack_d[owner_idx] = 1'b1;
          tx_wen_d         = 1'b1;
          tx_data_d        = data_sel;
        end
      end
      ST_HOLD: if (burst_done) gnt_d = '0;
      ST_GAP:  gnt_d = '0;
      default: gnt_d = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester bytes, round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int GT = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req, last, ack, gnt;
  logic [8*N-1:0] data;
  logic           baud_en, txrdy, tx_wen, busy;
  logic [7:0]     tx_data;

  int checks = 0;
  int errors = 0;

  // Per-requester byte FIFOs (what each client still has to send).
  logic [7:0] fb [N][256];
  bit         fl [N][256];
  int         head [N];
  int         tail [N];

  int  exp_q [$];   // idx*256 + byte, in expected transmit order
  int  seen  [$];   // owner index of every observed strobe
  int  mptr = 0;
  bit  rand_io = 1'b0;
  bit  prev_wen = 1'b0;
  int  e, sidx, n, n2;
  logic [N-1:0]  oh;
  logic [63:0]   ord;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .GAP_TICKS(GT)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .last    (last),
    .data    (data),
    .ack     (ack),
    .gnt     (gnt),
    .baud_en (baud_en),
    .txrdy   (txrdy),
    .tx_wen  (tx_wen),
    .tx_data (tx_data),
    .busy    (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] b, input bit l);
    if (head[i] == tail[i]) begin head[i] = 0; tail[i] = 0; end
    fb[i][tail[i]] = b;
    fl[i][tail[i]] = l;
    tail[i]++;
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (head[i] != tail[i]) begin
        req[i] = 1'b1; last[i] = fl[i][head[i]]; data[8*i +: 8] = fb[i][head[i]];
      end else begin
        req[i] = 1'b0; last[i] = 1'b0; data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) p = 1'b1;
    return p;
  endfunction

  // Reference: serve whole queues round-robin; a burst ends on LAST, MB bytes, or empty queue.
  task automatic model_run();
    int h [N];
    int sel, cnt;
    bit done, more;
    for (int k = 0; k < N; k++) h[k] = head[k];
    more = 1'b1;
    while (more) begin
      sel = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mptr + k) % N;
        if (sel < 0 && h[c] != tail[c]) sel = c;
      end
      if (sel < 0) begin
        more = 1'b0;
      end else begin
        cnt = 0; done = 1'b0;
        while (!done) begin
          exp_q.push_back(sel * 256 + int'(fb[sel][h[sel]]));
          cnt++;
          done = fl[sel][h[sel]] || (cnt == MB);
          h[sel]++;
          if (h[sel] == tail[sel]) done = 1'b1;
        end
        mptr = (sel + 1) % N;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (ack[i] && head[i] != tail[i]) head[i]++;
    refresh();
    if (rand_io) begin
      txrdy   = ($urandom_range(0, 3) != 0);
      baud_en = $urandom_range(0, 1);
    end
  endtask

  task automatic wait_done(input int limit, input string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy || pending()) && k < limit) begin
      cyc();
      k++;
    end
    chk({name, "_completed_in_budget"}, 64'(k < limit), 64'd1);
    chk({name, "_all_expected_bytes_seen"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (tx_wen === 1'b1) begin
      sidx = -1;
      for (int i = 0; i < N; i++) if (ack[i]) sidx = i;
      seen.push_back(sidx);
      if (prev_wen) begin
        checks++; errors++;
        $display("FAIL strobe_spacing: got back-to-back strobes required gap >= 1 cycle");
      end
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL strobe_unexpected: got ack=%b data=%h required no strobe", ack, tx_data);
      end else begin
        e  = exp_q.pop_front();
        oh = '0;
        oh[e / 256] = 1'b1;
        chk("strobe_ack_data", {ack, tx_data}, {oh, e[7:0]});
        chk("strobe_gnt_owner", gnt, oh);
      end
    end else if (ack !== '0) begin
      checks++; errors++;
      $display("FAIL ack_without_wen: got ack=%b required 0", ack);
    end
    prev_wen <= (tx_wen === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0; last = '0; data = '0; baud_en = 1'b0; txrdy = 1'b1;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end

    reset = 1'b1;
    cyc(); cyc();
    chk("reset_outputs", {gnt, ack, tx_wen, tx_data, busy}, 64'd0);
    reset = 1'b0;

    // Single byte latency and gap length
    push_byte(0, 8'hA5, 1'b1); model_run(); refresh();
    cyc(); chk("t2_gnt_plus1", {gnt, tx_wen, busy}, {4'b0001, 1'b0, 1'b1});
    cyc(); chk("t2_strobe_plus2", {tx_wen, ack, tx_data}, {1'b1, 4'b0001, 8'hA5});
    cyc(); chk("t2_release", {gnt, tx_wen, ack, busy}, {4'b0000, 1'b0, 4'b0000, 1'b1});
    baud_en = 1'b1; cyc(); baud_en = 1'b0; chk("t2_gap_tick1_busy", busy, 1);
    cyc(); chk("t2_gap_wait_busy", busy, 1);
    baud_en = 1'b1; cyc(); baud_en = 1'b0; chk("t2_idle_after_ticks", busy, 0);

    // Requester 1 drops REQ before LAST
    push_byte(1, 8'h11, 1'b0); model_run(); refresh();
    cyc(); chk("t6_gnt", gnt, 4'b0010);
    cyc(); chk("t6_strobe", {tx_wen, ack}, {1'b1, 4'b0010});
    cyc(); chk("t6_hold_keeps_gnt", gnt, 4'b0010);
    cyc(); chk("t6_drop_release", {gnt, tx_wen, busy}, {4'b0000, 1'b0, 1'b1});
    baud_en = 1'b1; cyc(); cyc(); baud_en = 1'b0; chk("t6_idle", busy, 0);
    for (int i = 0; i < 3; i++) push_byte(i, 8'h20 + 8'(i), 1'b1);
    model_run(); refresh();
    cyc(); chk("t6_ptr_advanced_to_2", gnt, 4'b0100);
    baud_en = 1'b1;
    wait_done(400, "t6");

    // Reset in the middle of a burst
    baud_en = 1'b0;
    for (int k = 0; k < 20; k++) push_byte(2, 8'h40 + 8'(k), k == 19);
    model_run(); refresh();
    n = 0;
    while (tx_wen !== 1'b1 && n < 10) begin cyc(); n++; end
    chk("t1_first_strobe_seen", tx_wen, 1);
    reset = 1'b1;
    cyc();
    chk("t1_reset_outputs", {gnt, ack, tx_wen, tx_data, busy}, 64'd0);
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    exp_q.delete(); mptr = 0; refresh();
    reset = 1'b0;
    push_byte(1, 8'h61, 1'b1); push_byte(3, 8'h63, 1'b1);
    model_run(); refresh();
    cyc(); chk("t1_ptr_reset_to_0", gnt, 4'b0010);
    baud_en = 1'b1;
    wait_done(400, "t1");

    // All four requesting: order 0,1,2,3,0
    seen.delete();
    push_byte(0, 8'h70, 1'b1); push_byte(0, 8'h71, 1'b1);
    push_byte(1, 8'h72, 1'b1); push_byte(2, 8'h73, 1'b1); push_byte(3, 8'h74, 1'b1);
    model_run(); refresh();
    wait_done(400, "t3");
    ord = '0;
    foreach (seen[k]) ord = (ord << 4) | 64'(seen[k]);
    chk("t3_grant_order", ord, 64'h01230);

    // Forced release after MB bytes
    seen.delete();
    for (int k = 0; k < 20; k++) push_byte(2, 8'h80 + 8'(k), k == 19);
    push_byte(3, 8'hEE, 1'b1);
    model_run(); refresh();
    wait_done(800, "t4");
    n2 = 0;
    while (n2 < seen.size() && seen[n2] == 2) n2++;
    chk("t4_forced_release_len", 64'(n2), 64'd16);
    chk("t4_next_owner", 64'((seen.size() > 16) ? seen[16] : -1), 64'd3);

    // TXRDY held low in LOAD; TXRDY high during HOLD
    baud_en = 1'b0; txrdy = 1'b0;
    push_byte(0, 8'h5A, 1'b0); push_byte(0, 8'hC3, 1'b1);
    model_run(); refresh();
    cyc();
    n = 0;
    for (int k = 0; k < 50; k++) begin cyc(); if (tx_wen === 1'b1) n++; end
    chk("t5_no_strobe_txrdy_low", 64'(n), 64'd0);
    txrdy = 1'b1;
    cyc(); chk("t5_strobe_after_txrdy", {tx_wen, tx_data}, {1'b1, 8'h5A});
    cyc(); chk("t5_hold_no_second_strobe", tx_wen, 0);
    cyc(); chk("t5_second_byte", {tx_wen, tx_data}, {1'b1, 8'hC3});
    baud_en = 1'b1;
    wait_done(400, "t5");

    // Randomised rounds
    rand_io = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        int nb;
        nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          int len;
          len = $urandom_range(1, 20);
          for (int k = 0; k < len; k++) push_byte(i, 8'($urandom), k == len - 1);
        end
      end
      model_run(); refresh();
      wait_done(8000, "rand");
    end
    rand_io = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
